cpu_dm_responder: RTL and testbench

// Memory-side responder for the CPU data-memory port (req/read/write/wait handshake).

---
 rtl/cpu_dm_responder.sv | 146 ++++++++++++++
 tb/tb_cpu_dm_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dm_responder.sv
// Memory-side responder for the CPU data port: serialises one load/store at a time
// onto a single-port SRAM, stalls the CPU with wait_o and counts completed accesses.
module cpu_dm_responder #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int MEM_AW    = 14,
  parameter int LATENCY   = 1,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [3:0]           web_i,
  output logic                 wait_o,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 mem_ceb_o,
  output logic [3:0]           mem_web_o,
  output logic [MEM_AW-1:0]    mem_a_o,
  output logic [DATA_BITS-1:0] mem_di_o,
  input  logic [DATA_BITS-1:0] mem_do_i,
  output logic [CNT_BITS-1:0]  rd_cnt_o,
  output logic [CNT_BITS-1:0]  wr_cnt_o,
  output logic [1:0]           state_o
);

  // Handshake: the CPU holds req_i with read_i/write_i; the access is taken in the
  // request cycle when idle, wait_o stays high until the access retires, and the
  // single low-wait cycle (DONE) is where the CPU advances and load data is valid.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          op_store;
  logic          accept;
  logic          lat_done;

  assign accept   = (state == IDLE) && req_i && (read_i || write_i);
  assign lat_done = (cnt == CNT_LAST);
  assign state_o  = state;

  // Address bits outside the SRAM word index are deliberately dropped (aliasing).
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_BITS-1:MEM_AW+2], addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = op_store ? DONE : HOLD;
      HOLD:    if (lat_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wait_o = 1'b0;
    case (state)
      IDLE:    wait_o = accept;
      ACCESS:  wait_o = 1'b1;
      HOLD:    wait_o = 1'b1;
      DONE:    wait_o = 1'b0;
      default: wait_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_store <= 1'b0;
    end else begin
      if (state_nxt == ACCESS) begin
        cnt <= '0;
      end else if (state == HOLD) begin
        cnt <= cnt + 1'b1;
      end
      // Store wins when both read_i and write_i are asserted.
      if (accept) begin
        op_store <= write_i;
      end
    end
  end

  // SRAM pins are registered at the accept edge so the ACCESS cycle sees them
  // directly from flops; mem_a_o/mem_di_o double as the address/data latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ceb_o <= 1'b1;
      mem_web_o <= 4'hF;
      mem_a_o   <= '0;
      mem_di_o  <= '0;
    end else if (accept) begin
      mem_ceb_o <= 1'b0;
      mem_web_o <= write_i ? web_i : 4'hF;
      mem_a_o   <= addr_i[MEM_AW+1:2];
      mem_di_o  <= wdata_i;
    end else begin
      mem_ceb_o <= 1'b1;
      mem_web_o <= 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o <= '0;
    end else if ((state == HOLD) && lat_done) begin
      rdata_o <= mem_do_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (state == DONE) begin
      if (op_store) begin
        if (wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + 1'b1;
      end else begin
        if (rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_dm_responder.sv
// Bench for cpu_dm_responder: two instances (LATENCY=1/CNT_BITS=2 and LATENCY=3/CNT_BITS=16)
// on one clock, each with its own SRAM model, checked against a word-level memory model.
module tb_cpu_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  web   [2];
  logic        wait_s[2];
  logic [31:0] rdata [2];
  logic        ceb   [2];
  logic [3:0]  mweb  [2];
  logic [13:0] ma    [2];
  logic [31:0] mdi   [2];
  logic [31:0] mdo   [2];
  logic [15:0] rdc   [2];
  logic [15:0] wrc   [2];
  logic [1:0]  st    [2];

  logic [31:0] sram [2][16384] = '{default: '0};
  logic [31:0] pipe [2][3] = '{default: '0};

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_mem [int];
  logic [31:0] exp_rdata [2];
  int          exp_rd [2];
  int          exp_wr [2];

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int cnt_max(input int g);
    return (g == 0) ? 3 : 65535;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int CB  = (g == 0) ? 2 : 16;
    logic [CB-1:0] rdc_w;
    logic [CB-1:0] wrc_w;
    cpu_dm_responder #(
      .ADDR_BITS(32), .DATA_BITS(32), .MEM_AW(14), .LATENCY(LAT), .CNT_BITS(CB)
    ) dut (
      .clk(clk), .rst(rst), .req_i(req[g]), .read_i(rd[g]), .write_i(wr[g]),
      .addr_i(addr[g]), .wdata_i(wdata[g]), .web_i(web[g]), .wait_o(wait_s[g]),
      .rdata_o(rdata[g]), .mem_ceb_o(ceb[g]), .mem_web_o(mweb[g]), .mem_a_o(ma[g]),
      .mem_di_o(mdi[g]), .mem_do_i(mdo[g]), .rd_cnt_o(rdc_w), .wr_cnt_o(wrc_w),
      .state_o(st[g])
    );
    assign rdc[g] = 16'(rdc_w);
    assign wrc[g] = 16'(wrc_w);
  end

  // SRAM model: read data enters a pipe on the enabled edge and emerges LATENCY edges later.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int i = 2; i > 0; i--) pipe[g][i] <= pipe[g][i-1];
      if (!ceb[g]) begin
        pipe[g][0] <= sram[g][ma[g]];
        for (int b = 0; b < 4; b++)
          if (!mweb[g][b]) sram[g][ma[g]][8*b +: 8] <= mdi[g][8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) mdo[g] = pipe[g][lat_of(g)-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int key);
    return exp_mem.exists(key) ? exp_mem[key] : 32'h0;
  endfunction

  // One CPU access on instance g; called just after a rising edge with the DUT idle.
  task automatic access(input int g, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit hold,
                        input string tag);
    int waits;
    int cebs;
    int key;
    logic [31:0] word;
    key = g * 65536 + int'(a[15:2]);
    req[g] = 1'b1; rd[g] = r; wr[g] = w; addr[g] = a; wdata[g] = d; web[g] = be;
    waits = 0;
    cebs = 0;
    @(negedge clk);
    while (wait_s[g] && waits < 40) begin
      waits++;
      if (!ceb[g]) cebs++;
      @(posedge clk);
      #1;
      if (!hold) begin
        req[g] = 1'($urandom); rd[g] = 1'($urandom); wr[g] = 1'($urandom);
        addr[g] = $urandom; wdata[g] = $urandom; web[g] = 4'($urandom);
      end
      @(negedge clk);
    end
    word = model_word(key);
    if (w) begin
      for (int b = 0; b < 4; b++) if (!be[b]) word[8*b +: 8] = d[8*b +: 8];
      exp_mem[key] = word;
      if (exp_wr[g] < cnt_max(g)) exp_wr[g]++;
    end else begin
      exp_rdata[g] = word;
      if (exp_rd[g] < cnt_max(g)) exp_rd[g]++;
    end
    check({tag, "_wait_cycles"}, waits, w ? 2 : lat_of(g) + 2);
    check({tag, "_ceb_low_cycles"}, cebs, 1);
    check({tag, "_rdata"}, rdata[g], exp_rdata[g]);
    @(posedge clk);
    #1;
    if (!hold) begin
      req[g] = 1'b0; rd[g] = 1'b0; wr[g] = 1'b0;
    end
    check({tag, "_rd_cnt"}, rdc[g], exp_rd[g]);
    check({tag, "_wr_cnt"}, wrc[g], exp_wr[g]);
    if (w) check({tag, "_sram_word"}, sram[g][a[15:2]], exp_mem[key]);
  endtask

  task automatic clear_model_after_reset();
    for (int g = 0; g < 2; g++) begin
      exp_rdata[g] = 32'h0;
      exp_rd[g] = 0;
      exp_wr[g] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bit r;
    bit w;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req[g] = 0; rd[g] = 0; wr[g] = 0; addr[g] = 0; wdata[g] = 0; web[g] = 4'hF;
    end
    clear_model_after_reset();
    #12;
    for (int g = 0; g < 2; g++) begin
      check("reset_wait", wait_s[g], 0);
      check("reset_rdata", rdata[g], 0);
      check("reset_ceb", ceb[g], 1);
      check("reset_mweb", mweb[g], 4'hF);
      check("reset_ma", ma[g], 0);
      check("reset_mdi", mdi[g], 0);
      check("reset_rd_cnt", rdc[g], 0);
      check("reset_wr_cnt", wrc[g], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LATENCY=1 load of a known word
    access(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'h0, 0, "preload_10");
    access(0, 1, 0, 32'h40, 32'h0, 4'hF, 0, "load_lat1");
    check("load_lat1_value", rdata[0], 32'hDEADBEEF);

    // byte-lane store over an existing word
    access(0, 0, 1, 32'h44, 32'h11223344, 4'h0, 0, "preload_11");
    access(0, 0, 1, 32'h44, 32'h000000AB, 4'b1110, 0, "byte_store");
    check("byte_store_word", sram[0][14'h11], 32'h112233AB);
    access(0, 1, 0, 32'h44, 32'h0, 4'hF, 0, "byte_load");

    // back-to-back with req held straight through DONE
    access(0, 0, 1, 32'h80, 32'h5A5A5A5A, 4'h0, 1, "b2b_store");
    access(0, 1, 0, 32'h80, 32'h0, 4'hF, 0, "b2b_load");
    check("b2b_load_value", rdata[0], 32'h5A5A5A5A);

    // read and write together behave as a store; web=F writes nothing
    access(0, 1, 1, 32'h84, 32'hCAFEF00D, 4'h0, 0, "rw_both");
    access(0, 0, 1, 32'h84, 32'hFFFFFFFF, 4'hF, 0, "store_no_lanes");
    access(0, 1, 0, 32'h84, 32'h0, 4'hF, 0, "load_after_nolane");

    // aliasing of upper address bits
    access(0, 0, 1, 32'h0010_0040, 32'h0BADCAFE, 4'h0, 0, "alias_store");
    access(0, 1, 0, 32'h40, 32'h0, 4'hF, 0, "alias_load");

    // request with neither read nor write is ignored
    req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b0; addr[0] = 32'h40;
    @(negedge clk);
    check("ignored_wait", wait_s[0], 0);
    @(negedge clk);
    check("ignored_ceb", ceb[0], 1);
    check("ignored_wait2", wait_s[0], 0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;

    // saturation of the 2-bit read counter
    for (int i = 0; i < 5; i++) access(0, 1, 0, 32'h80, 32'h0, 4'hF, 0, "sat_load");
    check("sat_rd_cnt", rdc[0], 3);

    // LATENCY=3 instance
    access(1, 0, 1, 32'h100, 32'h13579BDF, 4'h0, 0, "lat3_store");
    access(1, 1, 0, 32'h100, 32'h0, 4'hF, 0, "lat3_load");
    check("lat3_load_value", rdata[1], 32'h13579BDF);

    // reset during HOLD of a LATENCY=3 load
    req[1] = 1'b1; rd[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h100;
    @(posedge clk);
    #1;
    req[1] = 1'b0; rd[1] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_hold_wait", wait_s[1], 0);
    check("rst_hold_rdata", rdata[1], 0);
    check("rst_hold_ceb", ceb[1], 1);
    check("rst_hold_rd_cnt", rdc[1], 0);
    clear_model_after_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1, 1, 0, 32'h100, 32'h0, 4'hF, 0, "post_rst_load");
    check("post_rst_value", rdata[1], 32'h13579BDF);

    // randomized accesses over a small aliased window
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 24; i++) begin
        a = {16'($urandom), 2'b00, 12'(12'h200 + $urandom_range(0, 7)), 2'($urandom)};
        r = 1'($urandom);
        w = 1'($urandom);
        if (!r && !w) r = 1'b1;
        access(g, r, w, a, $urandom, 4'($urandom), 1'($urandom), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
